// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between the main control FSM and the
// HI/LO multiply/divide sequencer.
//   master (control FSM): drives start, op, a, b; observes the status/results
//   slave  (muldiv_seq) : samples start, op, a, b; drives busy, done,
//                         hilo_write, div0, hi, lo, state
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;       // funct[1:0]: bit1 0=mult 1=div, bit0 0=signed 1=unsigned
  logic [WIDTH-1:0] a;        // rs: multiplicand / dividend
  logic [WIDTH-1:0] b;        // rt: multiplier / divisor
  logic             busy;
  logic             done;
  logic             hilo_write;
  logic             div0;
  logic [WIDTH-1:0] hi;       // upper product / remainder
  logic [WIDTH-1:0] lo;       // lower product / quotient
  logic [2:0]       state;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_write, div0, hi, lo, state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_write, div0, hi, lo, state
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 multi-cycle sequencer for MIPS mult/multu/div/divu.
// One shift-add (multiply) or restoring-subtract (divide) step per clock;
// the 2*WIDTH-bit result is committed to HI/LO on entry to DONE.
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-low
//   bus   - muldiv_seq_if.slave: start/op/a/b in; busy/done/hilo_write/
//           div0/hi/lo/state out (all registered)
//
// Build option: define MULDIV_SIGNED_EN to honour op[0] (signed mult/div with
// sign correction in FIX). Without it every op is unsigned and FIX is a
// pass-through, so latency is the same in both builds.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  muldiv_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ITER = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    DIV0 = 3'd4
  } state_t;

  state_t             st;
  logic               busy_q, done_q, div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CW-1:0]      count;
  logic               op_div;
  logic [WIDTH-1:0]   opnd;   // |a| for mult, |b| for div
  logic [2*WIDTH-1:0] acc;    // mult: {partial, multiplier}; div: {rem, quotient}
`ifdef MULDIV_SIGNED_EN
  logic               neg_res;  // operand signs differ
  logic               neg_rem;  // dividend negative
`endif

  // operand magnitudes at start
  logic             sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sgn = ~bus.op[0];
`else
    sgn = 1'b0;
`endif
    // -0x80..0 wraps to itself, which is what the overflow case relies on
    mag_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // one iteration step of each algorithm
  logic [WIDTH:0]     msum, dtry;
  logic [2*WIDTH-1:0] mult_next, div_next;
  always_comb begin
    // shift-add: add multiplicand to upper half if LSB set, then shift right
    // keeping the carry
    msum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mult_next = {msum, acc[WIDTH-1:1]};
    // restoring divide: trial-subtract divisor from the shifted remainder;
    // keep the difference and shift in a 1 only if it did not go negative
    dtry      = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    div_next  = dtry[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                            : {dtry[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // FIX-stage result
  logic [WIDTH-1:0] res_hi, res_lo;
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    if (op_div) begin
      res_lo = neg_res ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
      res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      {res_hi, res_lo} = neg_res ? -acc : acc;
    end
`else
    {res_hi, res_lo} = acc;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st     <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      count  <= '0;
      op_div <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.start) begin
            op_div <= bus.op[1];
            busy_q <= 1'b1;
`ifdef MULDIV_SIGNED_EN
            neg_res <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem <= sgn & bus.a[WIDTH-1];
`endif
            if (bus.op[1]) begin
              opnd <= mag_b;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
            if (bus.op[1] && (bus.b == '0)) begin
              st <= DIV0;
            end else begin
              st    <= ITER;
              count <= CW'(WIDTH - 1);
            end
          end
        end
        ITER: begin
          acc   <= op_div ? div_next : mult_next;
          count <= count - CW'(1);
          if (count == '0) st <= FIX;
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          st     <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          st     <= IDLE;
        end
        DIV0: begin
          // two cycles here: the first raises the registered div0 pulse,
          // the second drops it and returns, so div0 sits between edges 1 and 2
          if (div0_q) begin
            div0_q <= 1'b0;
            busy_q <= 1'b0;
            st     <= IDLE;
          end else begin
            div0_q <= 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hilo_write = done_q;
  assign bus.div0       = div0_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.state      = st;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;  // model's view of HI/LO

  // reference: plain arithmetic on the architectural rules
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sg;
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub, uq, ur, up;
`ifdef MULDIV_SIGNED_EN
    sg = !op[0];
`else
    sg = 1'b0;
`endif
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    if (!op[1]) begin
      if (sg) begin p = sa * sb; return p; end
      up = ua * ub;
      return up;
    end
    if (b == 0) return 64'h0;
    if (sg) begin
      q = sa / sb; r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub; ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Issue one op at the current negedge and follow it edge by edge.
  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input bit ediv0, input bit inject);
    int last, ndone, ndiv0, done_e, div0_e, busy_err, hw_err, hold_err;
    logic [W-1:0] got_hi, got_lo;
    ndone = 0; ndiv0 = 0; done_e = -1; div0_e = -1; busy_err = 0; hw_err = 0; hold_err = 0;
    got_hi = '0; got_lo = '0;
    last = ediv0 ? 2 : W + 2;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    for (int e = 0; e <= last; e++) begin
      @(negedge clock);
      if (e == 0) begin
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
      end
      if (inject && e == 5) begin
        bus.start = 1'b1; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
      end
      if (inject && e == 6) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++; done_e = e; got_hi = bus.hi; got_lo = bus.lo;
        m_hi = eh; m_lo = el;
      end else if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        hold_err++;
      end
      if (bus.div0 === 1'b1) begin ndiv0++; div0_e = e; end
      if (bus.hilo_write !== bus.done) hw_err++;
      if (bus.busy !== (e < last)) busy_err++;
    end
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL %s end_state: got %0d want 0", name, bus.state); end
    checks++;
    if (busy_err != 0) begin errors++; $display("FAIL %s busy_window: got %0d bad cycles want 0", name, busy_err); end
    checks++;
    if (hw_err != 0) begin errors++; $display("FAIL %s hilo_write_eq_done: got %0d bad cycles want 0", name, hw_err); end
    checks++;
    if (hold_err != 0) begin errors++; $display("FAIL %s hilo_hold: got %0d bad cycles want 0", name, hold_err); end
    if (ediv0) begin
      checks++;
      if (ndiv0 != 1 || div0_e != 1) begin
        errors++; $display("FAIL %s div0_pulse: got %0d pulses at %0d want 1 at 1", name, ndiv0, div0_e);
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL %s no_done: got %0d want 0", name, ndone); end
    end else begin
      checks++;
      if (ndone != 1 || done_e != W + 1) begin
        errors++; $display("FAIL %s done_pulse: got %0d pulses at %0d want 1 at %0d", name, ndone, done_e, W + 1);
      end
      checks++;
      if (got_hi !== eh) begin errors++; $display("FAIL %s hi: got %h want %h", name, got_hi, eh); end
      checks++;
      if (got_lo !== el) begin errors++; $display("FAIL %s lo: got %h want %h", name, got_lo, el); end
      checks++;
      if (ndiv0 != 0) begin errors++; $display("FAIL %s no_div0: got %0d want 0", name, ndiv0); end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.state, bus.busy, bus.done, bus.hilo_write, bus.div0} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {bus.state, bus.busy, bus.done, bus.hilo_write, bus.div0});
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo}); end
    // reset and start together: reset wins
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clock);
    checks++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_wins: got state %0d busy %b want 0 0", bus.state, bus.busy);
    end
    bus.start = 1'b0; reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_release_idle: got %0d want 0", bus.state); end
  endtask

  task automatic test_multu_corner();
    do_op("multu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
  endtask

  task automatic test_mult_signed();
`ifdef MULDIV_SIGNED_EN
    do_op("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
`else
    do_op("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_div_signed();
`ifdef MULDIV_SIGNED_EN
    do_op("div_neg7by2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
`else
    do_op("div_neg7by2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0, 1'b0);
    do_op("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_div0();
    // 0x22222222 * 0x80000001 = 0x11111111_22222222 preloads HI/LO
    do_op("preload", 2'b01, 32'h22222222, 32'h80000001, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
    do_op("divu_by0", 2'b11, 32'd10, 32'd0, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    do_op("div_by0", 2'b10, 32'hFFFFFFF0, 32'd0, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
  endtask

  task automatic test_ignored_start();
    logic [63:0] r;
    r = model(2'b11, 32'd1000003, 32'd97);
    do_op("ignored_start_divu", 2'b11, 32'd1000003, 32'd97, r[63:32], r[31:0], 1'b0, 1'b1);
    r = model(2'b00, 32'h12345678, 32'hF0000001);
    do_op("ignored_start_mult", 2'b00, 32'h12345678, 32'hF0000001, r[63:32], r[31:0], 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int nd;
    nd = 0;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = $urandom; bus.b = $urandom;
    for (int e = 0; e < 10; e++) begin
      @(negedge clock);
      if (e == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) nd++;
    end
    reset = 1'b0;  // sampled at edge 10, the end of the 10th ITER cycle
    @(negedge clock);
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", bus.state); end
    checks++;
    if ({bus.busy, bus.done, bus.hilo_write, bus.div0, bus.hi, bus.lo} !== 68'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h want 0", {bus.busy, bus.done, bus.hilo_write, bus.div0, bus.hi, bus.lo});
    end
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clock);
      if (bus.done === 1'b1 || bus.div0 === 1'b1) nd++;
    end
    checks++;
    if (nd != 0 || bus.state !== 3'd0) begin
      errors++; $display("FAIL midreset_no_pulse: got %0d pulses state %0d want 0 0", nd, bus.state);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [W-1:0] a, b;
    logic [63:0] r;
    bit ez;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: a = '0;
        3: b = 32'd1;
        4: b = 32'($urandom_range(1, 255));
        default: ;
      endcase
      r  = model(op, a, b);
      ez = op[1] && (b == '0);
      do_op("rand", op, a, b, ez ? m_hi : r[63:32], ez ? m_lo : r[31:0], ez, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_multu_corner();
    test_mult_signed();
    test_div_signed();
    test_div0();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the CPU's HI/LO unit. It executes MIPS `mult`, `multu`, `div` and `divu` as one radix-2 iteration per clock and holds the 64-bit result in HI/LO. It sits beside the ALU and is started by the main control FSM, which stalls on `busy`. A divide by zero is reported to the main FSM as an exception so it can save EPC.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clock`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low. Low at a rising edge resets the block.
- `start`, in, 1: request an operation; sampled only in IDLE.
- `op`, in, 2: funct[1:0]. bit1: 0=mult, 1=div. bit0: 0=signed, 1=unsigned.
- `a`, in, WIDTH: rs value (multiplicand or dividend).
- `b`, in, WIDTH: rt value (multiplier or divisor).
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: one-cycle pulse when a result is committed.
- `hilo_write`, out, 1: equals `done`; write strobe for HI/LO.
- `hi`, out, WIDTH: upper product, or remainder.
- `lo`, out, WIDTH: lower product, or quotient.
- `div0`, out, 1: one-cycle pulse when a divide has a zero divisor.
- `state`, out, 3: current state, exported for debug.

## Operation
- States and encodings: IDLE=0, ITER=1, FIX=2, DONE=3, DIV0=4.
- IDLE, `start`=1:
  - Latch `op`, `a` and `b`. Later changes on `a`/`b` have no effect.
  - If divide and `b`==0: go to DIV0.
  - Otherwise: go to ITER with `count`=WIDTH-1.
- Signed operations:
  - ITER works on magnitudes |a| and |b|.
  - Operand signs are recorded at start.
- ITER, multiply: shift-add, 2·WIDTH-bit accumulator.
- ITER, divide: restoring divide, one quotient bit per cycle.
- ITER: `count` decrements each cycle; at `count`==0, go to FIX.
- FIX, signed only:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- FIX: go to DONE.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed):
  - Magnitude arithmetic wraps.
  - Result: lo=0x80000000, hi=0. No exception.
- DONE:
  - `hi`/`lo` registers are loaded on entry.
  - `done`=`hilo_write`=1 for this cycle.
  - Next state: IDLE.
- DIV0:
  - `div0`=1 for one cycle.
  - `hi`/`lo` unchanged, `done`=0.
  - Next state: IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `hi`/`lo` hold their last value in every state except DONE entry.

## Timing
- Edge 0 samples `start`.
- Normal operation:
  - Edges 1..WIDTH: iterations.
  - Edge WIDTH+1: FIX → DONE.
  - Edge WIDTH+2: DONE → IDLE.
  - For WIDTH=32, `done` is high between edges 33 and 34.
  - The earliest next `start` is sampled at edge 34.
- Divide by zero:
  - `div0` is high between edges 1 and 2.
  - Back in IDLE after edge 2.
- Reset values: `state`=IDLE, and `busy`, `done`, `hilo_write`, `div0`, `hi`, `lo`, `count` and all internal accumulators are 0.
- Reset mid-operation: at the first edge with `reset` low, the block goes to IDLE with the reset values. No `done` or `div0` pulse is produced.
- `reset` low and `start` high at the same edge: reset wins.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - `op[0]` selects signed or unsigned.
  - The FIX stage applies the sign correction.
- Not defined:
  - `op[0]` is ignored and every operation is unsigned.
  - FIX is still traversed as a pass-through, so latency is identical in both builds.

## Test plan
- `multu`, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `done` pulses once, after edge 33. `busy` is high from edge 0 to edge 34.
- `mult`, a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Requires `MULDIV_SIGNED_EN`; without it → hi=0x00000004, lo=0xFFFFFFF1.
- `div`, a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000, with `div0`=0.
- `divu`, a=10, b=0, with HI/LO preloaded with 0x11111111/0x22222222:
  - `div0` pulses after edge 1.
  - `done` and `hilo_write` stay 0.
  - HI/LO are unchanged.
  - Back in IDLE after edge 2.
- Ignored start and mid-operation reset:
  - `start` re-asserted with new operands during ITER → ignored; the result matches the first operands.
  - `reset` driven low at the 10th ITER cycle → at the next edge `state`=0, all outputs 0, and no `done` pulse.
